i_cache_ctrl: RTL and testbench

I_CACHE_CTRL -- requirements
Module: i_cache_ctrl

---
 rtl/i_cache_pkg.sv | 21 ++
 rtl/i_cache_if.sv | 24 ++
 rtl/i_cache_line_array.sv | 46 ++++
 rtl/i_cache_ctrl.sv | 119 +++++++++++
 tb/tb_i_cache_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/i_cache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
package i_cache_pkg;

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OFFSET_W   = 4;
  localparam int unsigned MEM_ADDR_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

  // Pick one 32-bit word out of a 16-byte block; word 0 sits in the low bits.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                 input logic [1:0]         w);
    return blk[{w, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/i_cache_if.sv
// CPU fetch port and instruction-memory block-read port of the cache.
interface i_cache_if;
  import i_cache_pkg::*;

  logic                  cpu_read;
  logic [31:0]           cpu_addr;
  logic [WORD_W-1:0]     cpu_instr;
  logic                  cpu_busywait;
  logic                  mem_read_en;
  logic [MEM_ADDR_W-1:0] mem_read_addr;
  logic                  mem_busywait;
  logic [BLOCK_W-1:0]    mem_read_data;

  modport slave (
    input  cpu_read, cpu_addr, mem_busywait, mem_read_data,
    output cpu_instr, cpu_busywait, mem_read_en, mem_read_addr
  );

  modport master (
    output cpu_read, cpu_addr, mem_busywait, mem_read_data,
    input  cpu_instr, cpu_busywait, mem_read_en, mem_read_addr
  );

endinterface

// File: rtl/i_cache_line_array.sv
// Valid/tag/data storage: one synchronous write port, one combinational read port.
module i_cache_line_array
  import i_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_W      = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] widx_i,
  input  logic [TAG_W-1:0]      wtag_i,
  input  logic [BLOCK_W-1:0]    wdata_i,
  input  logic [INDEX_BITS-1:0] ridx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [BLOCK_W-1:0]    rd_data_o
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rd_valid_o = valid_q[ridx_i];
  assign rd_tag_o   = tag_q[ridx_i];
  assign rd_data_o  = data_q[ridx_i];

endmodule

// File: rtl/i_cache_ctrl.sv
// Direct-mapped read-only instruction cache controller with zero-wait hits.
// Optional hit/miss counters are built when I_CACHE_STATS_EN is defined.
module i_cache_ctrl
  import i_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  i_cache_if.slave    bus
`ifdef I_CACHE_STATS_EN
  ,
  output logic [15:0] hit_count_o,
  output logic [15:0] miss_count_o
`endif
);

  localparam int unsigned TAG_W = 32 - INDEX_BITS - OFFSET_W;

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] blk_q, blk_d;
  logic                  rd_en_q;
  logic [MEM_ADDR_W-1:0] rd_addr_q;
  logic [WORD_W-1:0]     instr_q;

  logic                  fill_we_c;
  logic                  hit_c;
  logic [WORD_W-1:0]     word_c;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [BLOCK_W-1:0]    line_data;
  logic                  unused_byte_c;

  assign unused_byte_c = ^bus.cpu_addr[1:0];

  i_cache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (fill_we_c),
    .widx_i     (blk_q[INDEX_BITS-1:0]),
    .wtag_i     (blk_q[MEM_ADDR_W-1:INDEX_BITS]),
    .wdata_i    (bus.mem_read_data),
    .ridx_i     (bus.cpu_addr[INDEX_BITS+OFFSET_W-1:OFFSET_W]),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data)
  );

  // Lookups only count as hits in IDLE; during a fill the CPU is stalled anyway.
  assign hit_c  = bus.cpu_read && (state_q == ST_IDLE) && line_valid &&
                  (line_tag == bus.cpu_addr[31:INDEX_BITS+OFFSET_W]);
  assign word_c = word_sel(line_data, bus.cpu_addr[3:2]);

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    fill_we_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_read && !hit_c) begin
          blk_d   = bus.cpu_addr[31:OFFSET_W];
          state_d = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        if (!bus.mem_busywait) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        fill_we_c = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      blk_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      rd_en_q   <= (state_d == ST_MEM_READ);
      rd_addr_q <= (state_d == ST_MEM_READ) ? blk_d : '0;
      if (hit_c) instr_q <= word_c;
    end
  end

  assign bus.mem_read_en   = rd_en_q;
  assign bus.mem_read_addr = rd_addr_q;
  assign bus.cpu_instr     = hit_c ? word_c : instr_q;
  assign bus.cpu_busywait  = rst_n && ((state_q != ST_IDLE) || (bus.cpu_read && !hit_c));

`ifdef I_CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_c && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
      if ((state_q == ST_IDLE) && (state_d == ST_MEM_READ) && (miss_cnt_q != 16'hFFFF))
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_i_cache_ctrl.sv
// Bench for i_cache_ctrl: directed scenarios then random fetches against a cache/memory model.
module tb_i_cache_ctrl;
  localparam int unsigned IB = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i_cache_if bus ();

`ifdef I_CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  i_cache_ctrl #(.INDEX_BITS(IB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef I_CACHE_STATS_EN
    ,
    .hit_count_o  (hit_cnt),
    .miss_count_o (miss_cnt)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_lat = 4;
  int          mcnt = 0;
  logic        valid_m [8];
  logic [24:0] tag_m   [8];
  logic [31:0] last_instr;
  int          m_hits, m_misses;

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    logic [127:0] blk;
    if (b == 28'd0) return 128'h33332222_11110000_DDDDCCCC_BBBBAAAA;
    for (int w = 0; w < 4; w++)
      blk[w*32 +: 32] = (32'(b) * 32'h9E3779B1) + (32'(w) * 32'h01000193);
    return blk;
  endfunction

  function automatic logic [31:0] mem_word(input logic [27:0] b, input logic [1:0] w);
    logic [127:0] blk;
    blk = mem_block(b);
    return blk[32*int'(w) +: 32];
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return valid_m[a[6:4]] && (tag_m[a[6:4]] == a[31:7]);
  endfunction

  // Instruction memory: holds busywait for mem_lat-1 cycles of each block read.
  always @(posedge clk) begin
    #2;
    if (bus.mem_read_en) begin
      mcnt++;
      bus.mem_busywait  = (mcnt < mem_lat);
      bus.mem_read_data = mem_block(bus.mem_read_addr);
    end else begin
      mcnt = 0;
      bus.mem_busywait = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) valid_m[i] = 1'b0;
    last_instr = 32'd0;
    m_hits     = 0;
    m_misses   = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    logic        hit;
    logic [31:0] w;
    int          n;
    hit = model_hit(a);
    w   = mem_word(a[31:4], a[3:2]);
    bus.cpu_read = 1'b1;
    bus.cpu_addr = a;
    @(negedge clk);
    chk("busy_first", 32'(bus.cpu_busywait), 32'(!hit));
    if (!hit) begin
      chk("instr_hold_miss", bus.cpu_instr, last_instr);
      n = 1;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (k == 0) begin
          chk("rd_en", 32'(bus.mem_read_en), 32'd1);
          chk("rd_addr", 32'(bus.mem_read_addr), 32'(a[31:4]));
        end
        if (!bus.cpu_busywait) break;
        n++;
      end
      chk("miss_latency", 32'(n), 32'(mem_lat + 2));
      valid_m[a[6:4]] = 1'b1;
      tag_m[a[6:4]]   = a[31:7];
      m_misses++;
    end else begin
      chk("hit_no_rd", 32'(bus.mem_read_en), 32'd0);
    end
    chk("instr", bus.cpu_instr, w);
    last_instr = w;
    m_hits++;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    bus.cpu_read = 1'b0;
    bus.cpu_addr = $urandom;
    @(negedge clk);
    chk("idle_busy", 32'(bus.cpu_busywait), 32'd0);
    chk("idle_instr_hold", bus.cpu_instr, last_instr);
    chk("idle_rd_en", 32'(bus.mem_read_en), 32'd0);
    @(posedge clk); #1;
  endtask

  // Miss on a, then move the CPU address to b mid-fill; the fill must still target a.
  task automatic fill_disturbed(input logic [31:0] a, input logic [31:0] b);
    bus.cpu_read = 1'b1;
    bus.cpu_addr = a;
    @(negedge clk);
    chk("dist_busy", 32'(bus.cpu_busywait), 32'd1);
    @(negedge clk);
    chk("dist_rd_addr", 32'(bus.mem_read_addr), 32'(a[31:4]));
    @(posedge clk); #1;
    bus.cpu_addr = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.mem_read_en) break;
      chk("dist_rd_addr_kept", 32'(bus.mem_read_addr), 32'(a[31:4]));
    end
    chk("dist_update_busy", 32'(bus.cpu_busywait), 32'd1);
    chk("dist_update_en", 32'(bus.mem_read_en), 32'd0);
    valid_m[a[6:4]] = 1'b1;
    tag_m[a[6:4]]   = a[31:7];
    m_misses++;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst_n             = 1'b0;
    bus.cpu_read      = 1'b1;
    bus.cpu_addr      = 32'd0;
    bus.mem_busywait  = 1'b0;
    bus.mem_read_data = '0;
    model_reset();

    @(negedge clk);
    chk("rst_busy", 32'(bus.cpu_busywait), 32'd0);
    chk("rst_rd_en", 32'(bus.mem_read_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.mem_read_addr), 32'd0);
    chk("rst_instr", bus.cpu_instr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    mem_lat = 16;
    fetch(32'h0000_0000);
    idle_cycle();
    chk("word0_const", bus.cpu_instr, 32'hBBBBAAAA);
    mem_lat = 3;
    fetch(32'h0000_000C);
    chk("word3_const", bus.cpu_instr, 32'h33332222);
    fetch(32'h0000_0080);
    fetch(32'h0000_0000);
`ifdef I_CACHE_STATS_EN
    chk("stat_miss", 32'(miss_cnt), 32'd3);
    chk("stat_hit", 32'(hit_cnt), 32'd4);
`endif

    mem_lat = 4;
    fill_disturbed(32'h0000_0150, 32'h0000_0264);
    fetch(32'h0000_0264);
    fetch(32'h0000_0158);

    // Reset asserted in the middle of a fill.
    mem_lat = 10;
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'h0000_0100;
    repeat (4) @(negedge clk);
    chk("pre_rst_rd_en", 32'(bus.mem_read_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(bus.mem_read_en), 32'd0);
    chk("mid_rst_rd_addr", 32'(bus.mem_read_addr), 32'd0);
    chk("mid_rst_busy", 32'(bus.cpu_busywait), 32'd0);
    chk("mid_rst_instr", bus.cpu_instr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    mem_lat = 2;
    fetch(32'h0000_0000);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle();
      end else begin
        a        = 32'($urandom_range(0, 15));
        a[6:4]   = 3'($urandom_range(0, 7));
        a[31:7]  = 25'($urandom_range(0, 3)) * 25'h0123457;
        mem_lat  = $urandom_range(1, 5);
        fetch(a);
      end
    end

`ifdef I_CACHE_STATS_EN
    chk("stat_miss_end", 32'(miss_cnt), 32'(m_misses));
    chk("stat_hit_end", 32'(hit_cnt), 32'(m_hits));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
